// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display path: glyph table, special codes,
// scan-reader FSM states and a small enable-counting helper.
package display_pkg;

    // Scan-reader FSM states.
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } scan_state_t;

    // Special codes with dedicated glyphs.
    localparam logic [3:0] CODE_SUPPLY  = 4'hB;  // top bar only
    localparam logic [3:0] CODE_ERR_MID = 4'hC;  // middle bar only
    localparam logic [3:0] CODE_ERR_LOW = 4'hD;  // bottom bar only

    // Idle levels of the scanned lines: all enables high, all segments dark.
    localparam logic [3:0] DISPLAY_BLANK = 4'b1111;
    localparam logic [6:0] SEG_DARK      = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for each code. The all-lit pattern is kept
    // free as a lamp-test/fault signature, so 8 is drawn without segment a.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h01,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h7E,  // B  CODE_SUPPLY
        7'h3F,  // C  CODE_ERR_MID
        7'h77,  // D  CODE_ERR_LOW
        7'h06,  // E
        7'h0E   // F
    };

    // Number of asserted (low) digit enables.
    function automatic logic [2:0] low_count(input logic [3:0] enables);
        low_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            low_count = low_count + {2'b00, ~enables[i]};
        end
    endfunction

endpackage

// File: rtl/seg_glyph_lookup.sv
// Combinational reverse search of the glyph table: segment pattern -> {hit, code}.
module seg_glyph_lookup
    import display_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic [3:0] code
);

    // Scan from the highest code down so the lowest matching code is the one left.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        hit  = 1'b0;
        code = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (SEG_GLYPH[i] == pattern) begin
                hit  = 1'b1;
                code = 4'(i);
            end
        end
    end

endmodule

// File: rtl/display_scan_reader.sv
// Receive side of the multiplexed 4-digit display: waits for each scanned digit to
// settle, decodes it, assembles a frame and offers it through valid/ready.
module display_scan_reader
    import display_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic [3:0] display_n,
    input  logic       frame_ready,
    output logic [3:0] digit_3,
    output logic [3:0] digit_2,
    output logic [3:0] digit_1,
    output logic [3:0] digit_0,
    output logic       frame_valid,
    output logic       glyph_err,
    output logic       multi_err,
    output logic       timeout,
    output logic       overrun
);

    localparam int SETTLE_W = $clog2(STABLE_CYCLES) + 1;
    localparam int TMO_W    = $clog2(FRAME_TIMEOUT) + 1;
    // The lookup fires on the increment that brings the count to STABLE_CYCLES-1.
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(STABLE_CYCLES - 2);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(FRAME_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]    TMO_MAX     = '1;

    logic [6:0]          seg_q, seg_p;
    logic [3:0]          disp_q, disp_p;
    scan_state_t         state, state_n;
    logic [SETTLE_W-1:0] settle_cnt, settle_n;
    logic                lookup_en;
    logic                hit;
    logic [3:0]          code;
    logic [1:0]          digit_idx;
    logic                sample_valid, sample_multi, sample_same;
    logic [3:0]          shadow [4];
    logic [3:0]          seen, seen_base;
    logic                frame_done, capture;
    logic [TMO_W-1:0]    tmo_cnt;

    seg_glyph_lookup u_lookup (
        .pattern (seg_q),
        .hit     (hit),
        .code    (code)
    );

    assign sample_valid = (low_count(disp_q) == 3'd1);
    assign sample_multi = (low_count(disp_q) > 3'd1);
    assign sample_same  = ({disp_q, seg_q} == {disp_p, seg_p});
    assign capture      = lookup_en & hit;
    assign frame_done   = (seen == 4'b1111);
    assign seen_base    = frame_done ? 4'b0000 : seen;

    // Position of the single low enable in the current sample.
    always_comb begin
        case (disp_q)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: digit_idx = 2'd0;
        endcase
    end

    // Input stage plus one sample of history for the settle comparison.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            seg_q  <= SEG_DARK;
            disp_q <= DISPLAY_BLANK;
            seg_p  <= SEG_DARK;
            disp_p <= DISPLAY_BLANK;
        end else begin
            seg_q  <= seg_in;
            disp_q <= display_n;
            seg_p  <= seg_q;
            disp_p <= disp_q;
        end
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_n;
        end
    end

    // Next state: settle on a steady single-digit sample, look it up once per enable interval.
    always_comb begin
        state_n   = state;
        settle_n  = settle_cnt;
        lookup_en = 1'b0;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    state_n  = SETTLE;
                    settle_n = '0;
                end
            end
            SETTLE: begin
                if (!sample_same) begin
                    state_n  = sample_valid ? SETTLE : IDLE;
                    settle_n = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    lookup_en = 1'b1;
                    state_n   = CAPTURED;
                    settle_n  = settle_cnt + 1'b1;
                end else begin
                    settle_n = settle_cnt + 1'b1;
                end
            end
            CAPTURED: begin
                if (!sample_same) begin
                    state_n  = sample_valid ? SETTLE : IDLE;
                    settle_n = '0;
                end
            end
            default: begin
                state_n  = IDLE;
                settle_n = '0;
            end
        endcase
    end

    // Shadow/seen assembly, frame hand-off, timeout and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the shadow file is four nibbles that must read 0 after reset, so it is reset like plain flops.
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 4'h0;
            end
            seen        <= 4'b0000;
            tmo_cnt     <= '0;
            digit_3     <= 4'h0;
            digit_2     <= 4'h0;
            digit_1     <= 4'h0;
            digit_0     <= 4'h0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            glyph_err   <= 1'b0;
            multi_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            glyph_err <= lookup_en & ~hit;
            multi_err <= sample_multi;
            timeout   <= 1'b0;

            if (frame_done) begin
                digit_3 <= shadow[3];
                digit_2 <= shadow[2];
                digit_1 <= shadow[1];
                digit_0 <= shadow[0];
                if (frame_valid && !frame_ready) begin
                    overrun <= 1'b1;
                end
            end
            frame_valid <= frame_done | (frame_valid & ~frame_ready);

            if (capture) begin
                shadow[digit_idx] <= code;
                seen              <= seen_base | (4'b0001 << digit_idx);
                tmo_cnt           <= '0;
            end else if ((seen_base != 4'b0000) && (tmo_cnt >= TMO_LAST)) begin
                timeout <= 1'b1;
                seen    <= 4'b0000;
                tmo_cnt <= '0;
            end else begin
                seen <= seen_base;
                if (tmo_cnt != TMO_MAX) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scan_reader.sv
// Directed bench for display_scan_reader with a run-length behavioural model
// checked every cycle, plus literal expectations at the end of each scenario.
module tb_display_scan_reader;

    localparam int STABLE = 4;
    localparam int TMO    = 1024;

    // Active-low {g,f,e,d,c,b,a} glyphs, drawn independently from the segment letters.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h01, 7'h10, 7'h08, 7'h7E, 7'h3F, 7'h77, 7'h06, 7'h0E
    };

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_in = 7'h7F;
    logic [3:0] display_n = 4'hF;
    logic       frame_ready = 1'b0;
    logic [3:0] digit_3, digit_2, digit_1, digit_0;
    logic       frame_valid, glyph_err, multi_err, timeout, overrun;

    always #5 clock = ~clock;

    display_scan_reader #(
        .STABLE_CYCLES (STABLE),
        .FRAME_TIMEOUT (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .seg_in      (seg_in),
        .display_n   (display_n),
        .frame_ready (frame_ready),
        .digit_3     (digit_3),
        .digit_2     (digit_2),
        .digit_1     (digit_1),
        .digit_0     (digit_0),
        .frame_valid (frame_valid),
        .glyph_err   (glyph_err),
        .multi_err   (multi_err),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A digit is taken when the same single-enable sample has been seen STABLE times
    // in a row; effects appear one clock after that sample.
    logic [10:0] m_sample = {4'hF, 7'h7F};
    int          m_run = 1;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_seen = '0;
    int          m_idle = 0;
    logic [15:0] m_digits = '0;
    logic        m_valid = 0, m_glyph = 0, m_multi = 0, m_timeout = 0, m_overrun = 0;
    int          m_zeros, m_idx;
    logic        m_hit, m_took;
    logic [3:0]  m_code;

    always @(posedge clock) begin
        if (reset) begin
            m_sample  = {4'hF, 7'h7F};
            m_run     = 1;
            m_shadow  = '0;
            m_seen    = '0;
            m_idle    = 0;
            m_digits  = '0;
            m_valid   = 0;
            m_glyph   = 0;
            m_multi   = 0;
            m_timeout = 0;
            m_overrun = 0;
        end else begin
            m_zeros = 0;
            m_idx   = 0;
            for (int i = 0; i < 4; i++) begin
                if (!m_sample[7+i]) begin
                    m_zeros++;
                    m_idx = i;
                end
            end
            m_multi   = (m_zeros > 1);
            m_glyph   = 0;
            m_timeout = 0;
            m_took    = 0;

            if (m_seen == 4'hF) begin
                if (m_valid && !frame_ready) m_overrun = 1;
                m_digits = m_shadow;
                m_valid  = 1;
                m_seen   = 4'h0;
            end else if (frame_ready) begin
                m_valid = 0;
            end

            if (m_zeros == 1 && m_run == STABLE) begin
                m_hit  = 0;
                m_code = 4'h0;
                for (int c = 15; c >= 0; c--) begin
                    if (GLYPH[c] == m_sample[6:0]) begin
                        m_hit  = 1;
                        m_code = 4'(c);
                    end
                end
                if (m_hit) begin
                    m_shadow[4*m_idx +: 4] = m_code;
                    m_seen[m_idx]          = 1'b1;
                    m_idle                 = 0;
                    m_took                 = 1;
                end else begin
                    m_glyph = 1;
                end
            end

            if (!m_took) begin
                if (m_seen != 4'h0 && m_idle >= TMO - 1) begin
                    m_timeout = 1;
                    m_seen    = 4'h0;
                    m_idle    = 0;
                end else begin
                    m_idle++;
                end
            end

            if ({display_n, seg_in} == m_sample) m_run++;
            else m_run = 1;
            m_sample = {display_n, seg_in};
        end
    end

    // ---------------- per-cycle compare ----------------
    logic cmp_en = 0;
    int   fv_count = 0, glyph_count = 0, multi_count = 0, tmo_count = 0;

    always @(negedge clock) begin
        if (cmp_en) begin
            check("digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'(m_digits));
            check("frame_valid", 32'(frame_valid), 32'(m_valid));
            check("glyph_err", 32'(glyph_err), 32'(m_glyph));
            check("multi_err", 32'(multi_err), 32'(m_multi));
            check("timeout", 32'(timeout), 32'(m_timeout));
            check("overrun", 32'(overrun), 32'(m_overrun));
            if (frame_valid) fv_count++;
            if (glyph_err)   glyph_count++;
            if (multi_err)   multi_count++;
            if (timeout)     tmo_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] seg, input int cycles);
        display_n = en;
        seg_in    = seg;
        repeat (cycles) tick();
    endtask

    task automatic show(input int idx, input logic [3:0] code, input int cycles);
        drive(~(4'b0001 << idx), GLYPH[code], cycles);
    endtask

    task automatic blank(input int cycles);
        drive(4'hF, 7'h7F, cycles);
    endtask

    task automatic scan(input logic [3:0] c3, input logic [3:0] c2, input logic [3:0] c1, input logic [3:0] c0);
        show(3, c3, 8);
        show(2, c2, 8);
        show(1, c1, 8);
        show(0, c0, 8);
        blank(4);
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({digit_3, digit_2, digit_1, digit_0, frame_valid, glyph_err, multi_err, timeout, overrun});
    endfunction

    int base_fv, base_glyph, base_multi, base_tmo, first_glyph;

    initial begin
        // Reset state
        reset = 1;
        tick();
        tick();
        cmp_en = 1;
        check("reset_outputs", all_outputs(), 32'h0);
        reset = 0;
        blank(3);

        // 1: plain frame 1,2,3,4 with consumer always ready
        frame_ready = 1;
        base_fv = fv_count;
        scan(4'h1, 4'h2, 4'h3, 4'h4);
        check("t1_valid_cycles", 32'(fv_count - base_fv), 32'd1);
        check("t1_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h1234);

        // 2: 3-cycle holds never capture; a held 4th digit alone leaves the frame open
        base_fv = fv_count;
        show(3, 4'h5, 3);
        show(2, 4'h6, 3);
        show(1, 4'h7, 3);
        show(0, 4'h8, 10);
        blank(4);
        check("t2_no_frame", 32'(fv_count - base_fv), 32'd0);
        check("t2_digits_kept", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h1234);
        show(3, 4'h9, 8);
        show(2, 4'hA, 8);
        show(1, 4'hB, 8);
        blank(4);
        check("t2_frame_with_held_d0", 32'(fv_count - base_fv), 32'd1);
        check("t2_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h9AB8);

        // 3: two enables low for two samples
        base_multi = multi_count;
        base_fv    = fv_count;
        drive(4'b0011, GLYPH[5], 2);
        blank(4);
        check("t3_multi_cycles", 32'(multi_count - base_multi), 32'd2);
        check("t3_no_frame", 32'(fv_count - base_fv), 32'd0);
        check("t3_digits_kept", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h9AB8);

        // 4: unknown all-lit pattern on display_0, then the error frame B,C,C,D
        reset = 1;
        tick();
        reset = 0;
        blank(2);
        base_fv    = fv_count;
        base_glyph = glyph_count;
        show(3, 4'hB, 8);
        show(2, 4'hC, 8);
        show(1, 4'hC, 8);
        display_n   = 4'b1110;
        seg_in      = 7'h00;
        first_glyph = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (glyph_err && first_glyph == 0) first_glyph = k;
        end
        check("t4_glyph_latency", 32'(first_glyph), 32'(STABLE + 1));
        check("t4_glyph_pulses", 32'(glyph_count - base_glyph), 32'd1);
        check("t4_no_frame_on_miss", 32'(fv_count - base_fv), 32'd0);
        show(0, 4'hD, 8);
        blank(4);
        check("t4_frame", 32'(fv_count - base_fv), 32'd1);
        check("t4_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'hBCCD);

        // 5: consumer stalled across two frames
        frame_ready = 0;
        scan(4'h5, 4'h6, 4'h7, 4'h8);
        check("t5_first_valid", 32'(frame_valid), 32'd1);
        check("t5_first_no_overrun", 32'(overrun), 32'd0);
        check("t5_first_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h5678);
        scan(4'h9, 4'h0, 4'h1, 4'h2);
        check("t5_overrun", 32'(overrun), 32'd1);
        check("t5_valid_held", 32'(frame_valid), 32'd1);
        check("t5_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h9012);
        frame_ready = 1;
        tick();
        frame_ready = 0;
        check("t5_consumed", 32'(frame_valid), 32'd0);
        check("t5_overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a scan clears everything on the next edge
        show(3, 4'h3, 8);
        show(2, 4'h4, 3);
        reset = 1;
        tick();
        check("reset_mid_scan", all_outputs(), 32'h0);
        reset = 0;
        blank(3);

        // 6: partial frame abandoned for longer than the timeout
        frame_ready = 1;
        base_fv  = fv_count;
        base_tmo = tmo_count;
        show(3, 4'h1, 8);
        show(2, 4'h2, 8);
        show(1, 4'h3, 8);
        blank(TMO + 20);
        check("t6_timeout_pulses", 32'(tmo_count - base_tmo), 32'd1);
        show(0, 4'h4, 8);
        blank(4);
        check("t6_seen_cleared", 32'(fv_count - base_fv), 32'd0);
        check("t6_digits_untouched", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
